cpu_seq_ctrl: RTL
=================

CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of serial bit cycles per execute; legal range 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port btn_in  input  1  raw load push button, active-high.
REQ-005 SHALL have port din  input  8  DIP-switch instruction byte.
REQ-006 SHALL have port instr  output  16  assembled instruction register.
REQ-007 SHALL have port le  output  1  datapath shift-register parallel-load enable.
REQ-008 SHALL have port ae  output  1  ALU accumulate enable, one serial bit per cycle.
REQ-009 SHALL have port bit_idx  output  4  current serial bit index, LSB first.
REQ-010 SHALL have port busy  output  1  high in EXEC and DONE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port state_o  output  3  state code: LO=1, HI=2, EXEC=3, DONE=4.
REQ-013 SHALL have port seg  output  7  7-seg status, gfedcba, active-high.

Function
REQ-014 SHALL detect a "press" as a rising edge of btn_in (held-high button counts once).
REQ-015 SHALL implement FSM LO -> HI -> EXEC -> DONE -> LO; all outputs registered, with no combinational path from any input to any output.
REQ-016 LO: on press, instr[7:0] <= din; instr[15:8] unchanged; next HI.
REQ-017 HI: on press, instr[15:8] <= din; next EXEC.
REQ-018 EXEC SHALL last exactly WIDTH+1 cycles: first cycle le=1, ae=0; then WIDTH cycles ae=1, le=0, bit_idx = 0,1,...,WIDTH-1.
REQ-019 le and ae SHALL never be high together; both SHALL be low outside EXEC.
REQ-020 bit_idx SHALL be 0 outside ae cycles; it SHALL not wrap within one execute.
REQ-021 DONE SHALL last one cycle with done=1, then return to LO.
REQ-022 Presses in EXEC or DONE SHALL be ignored and not queued; a button still held on return to LO SHALL not count until released and re-pressed.
REQ-023 instr SHALL be stable from entry to EXEC until the next LO press.
REQ-024 seg SHALL show LO 'L'=0111000, HI 'H'=1110110, EXEC '-'=1000000, DONE 'd'=1011110.

Reset
REQ-025 On rst_n low, immediately: state LO, instr=0, le=0, ae=0, bit_idx=0, busy=0, done=0, state_o=1, seg='L', edge-detect history = button released.
REQ-026 Reset mid-EXEC SHALL abort without a done pulse; after release, operation restarts from LO.

Configuration
REQ-027 Macro CPU_SEQ_BTN_SYNC_EN defined: btn_in SHALL pass a 2-flop synchronizer before edge detection; a press first sampled high at edge N takes effect at edge N+2.
REQ-028 Macro undefined: btn_in SHALL feed edge detection directly; the press takes effect at edge N; all other behaviour identical.

Verification
REQ-029 Reset, then press with din=0x34, then press with din=0x12 -> instr=0x1234; states LO->HI->EXEC.
REQ-030 WIDTH=8 execute -> le high 1 cycle, then ae high 8 cycles with bit_idx 0..7, done pulse on the following cycle, total 10 cycles from EXEC entry to LO.
REQ-031 Button held high 20 cycles in LO -> exactly one byte captured; state HI.
REQ-032 Press during EXEC and during DONE -> instr unchanged, no extra state advance.
REQ-033 rst_n low at EXEC bit_idx=3 -> all outputs at reset values asynchronously; no done pulse.
REQ-034 Run the same press stimulus with and without CPU_SEQ_BTN_SYNC_EN -> capture occurs 2 cycles later with the macro defined; results otherwise identical.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Load/execute sequencer: two button presses assemble a 16-bit instruction, then WIDTH serial ALU cycles run.
// Optional macro CPU_SEQ_BTN_SYNC_EN inserts a 2-flop synchronizer ahead of button edge detection.
module cpu_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_in,
  input  logic [7:0]  din,
  output logic [15:0] instr,
  output logic        le,
  output logic        ae,
  output logic [3:0]  bit_idx,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_o,
  output logic [6:0]  seg
);

  typedef enum logic [2:0] {
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_EXEC = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [4:0] LAST    = 5'(WIDTH);
  localparam logic [6:0] SEG_L   = 7'b0111000;
  localparam logic [6:0] SEG_H   = 7'b1110110;
  localparam logic [6:0] SEG_EX  = 7'b1000000;
  localparam logic [6:0] SEG_D   = 7'b1011110;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [15:0] instr_n;
  logic        le_n, ae_n, busy_n, done_n;
  logic [3:0]  bit_idx_n;
  logic [4:0]  idx_full;
  logic [6:0]  seg_n;
  logic        btn_s, btn_prev, press;

`ifdef CPU_SEQ_BTN_SYNC_EN
  logic sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end
  assign btn_s = sync2;
`else
  assign btn_s = btn_in;
`endif

  // History tracks the button in every state so a press held across DONE->LO never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_prev <= 1'b0;
    else        btn_prev <= btn_s;
  end
  assign press = btn_s & ~btn_prev;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    instr_n = instr;
    case (state)
      ST_LO: begin
        if (press) begin
          instr_n[7:0] = din;
          state_n      = ST_HI;
        end
      end
      ST_HI: begin
        if (press) begin
          instr_n[15:8] = din;
          cnt_n         = 5'd0;
          state_n       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == LAST) begin
          cnt_n   = 5'd0;
          state_n = ST_DONE;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      ST_DONE: begin
        cnt_n   = 5'd0;
        state_n = ST_LO;
      end
      default: begin
        cnt_n   = 5'd0;
        state_n = ST_LO;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    le_n      = (state_n == ST_EXEC) && (cnt_n == 5'd0);
    ae_n      = (state_n == ST_EXEC) && (cnt_n != 5'd0);
    idx_full  = cnt_n - 5'd1;
    bit_idx_n = ae_n ? idx_full[3:0] : 4'd0;
    busy_n    = (state_n == ST_EXEC) || (state_n == ST_DONE);
    done_n    = (state_n == ST_DONE);
    case (state_n)
      ST_HI:   seg_n = SEG_H;
      ST_EXEC: seg_n = SEG_EX;
      ST_DONE: seg_n = SEG_D;
      default: seg_n = SEG_L;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LO;
      cnt     <= 5'd0;
      instr   <= 16'd0;
      le      <= 1'b0;
      ae      <= 1'b0;
      bit_idx <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      state_o <= ST_LO;
      seg     <= SEG_L;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      instr   <= instr_n;
      le      <= le_n;
      ae      <= ae_n;
      bit_idx <= bit_idx_n;
      busy    <= busy_n;
      done    <= done_n;
      state_o <= state_n;
      seg     <= seg_n;
    end
  end

endmodule
